pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  RESET_PC  32'h0000_0000  PC value loaded on reset.
  NOP_INST  32'h0000_0013  Instruction word placed in the ID register on any bubble.
REQ-002 Clocking SHALL be one clock, clk; reset SHALL be rst, synchronous and active-high.
REQ-003 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  npc  in  32  next PC from the next-PC unit
  redirect  in  1  npc is an EX-stage branch/jump target; flush younger work
  stall  in  1  hazard unit holds ID and PC
  pc  out  32  current fetch PC (pc_now to next-PC unit)
  imem_req  out  1  instruction memory request
  imem_addr  out  32  fetch address
  imem_ack  in  1  imem_rdata valid for the current imem_addr, same cycle
  imem_rdata  in  32  instruction word
  id_valid  out  1  IF/ID register holds a real instruction
  id_pc  out  32  PC of id_inst
  id_inst  out  32  instruction to decode
  fetch_cnt  out  32  count of instructions delivered to ID

Function
REQ-004 The FSM SHALL have two states: FETCH and HOLD.
REQ-005 In FETCH: imem_req=1 and imem_addr=pc. In HOLD: imem_req=0 and imem_addr=pc.
REQ-006 Every PC update SHALL load {npc[31:2],2'b00}.
REQ-007 Priority in every state SHALL be redirect > stall > normal.
REQ-008 In FETCH with redirect=1, regardless of ack or stall:
  - pc<=npc, id_valid<=0, id_inst<=NOP_INST
  - any acked word is discarded; next state FETCH.
REQ-009 In FETCH with ack=1, redirect=0, stall=1:
  - imem_rdata and pc are captured into a one-entry skid buffer
  - pc, id_* hold; next state HOLD.
REQ-010 In FETCH with ack=1, redirect=0, stall=0:
  - id_pc<=pc, id_inst<=imem_rdata, id_valid<=1, pc<=npc
  - fetch_cnt increments; next state FETCH.
REQ-011 In FETCH with ack=0, redirect=0:
  - stall=1: pc and id_* hold.
  - stall=0: bubble (id_valid<=0, id_inst<=NOP_INST, id_pc holds); pc holds.
REQ-012 In HOLD with redirect=1: skid buffer dropped, pc<=npc, bubble into ID, next state FETCH.
REQ-013 In HOLD with stall=1, redirect=0: all state holds.
REQ-014 In HOLD with stall=0, redirect=0:
  - id_pc/id_inst<=skid buffer, id_valid<=1, pc<=npc
  - fetch_cnt increments; next state FETCH.
REQ-015 Full-cycle latency SHALL be one cycle: an acked word appears on id_* the next cycle when unstalled.
REQ-016 fetch_cnt SHALL wrap from 32'hFFFF_FFFF to 0, and SHALL NOT increment on bubbles or discarded words.
REQ-017 No acked word SHALL ever be lost or delivered twice.
REQ-018 No word fetched before a redirect SHALL reach ID with id_valid=1.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL enter reset state:
  - pc=RESET_PC, state=FETCH, skid buffer empty
  - id_valid=0, id_pc=0, id_inst=NOP_INST, fetch_cnt=0
REQ-020 rst SHALL override all other inputs, including mid-HOLD and mid-redirect.
REQ-021 imem_req=1 in the first cycle after reset deasserts.

Verification
REQ-022 Reset then ack every cycle, npc=pc+4 -> id_pc sequence 0,4,8,...; id_valid=1 from cycle 2; fetch_cnt=3 after 3 deliveries.
REQ-023 Ack held 0 for 3 cycles at pc=0x10 -> imem_addr stays 0x10, id_valid=0 for 3 cycles, pc unchanged.
REQ-024 Ack with stall=1 at pc=0x20, inst=0xDEADBEEF, stall held 2 cycles -> state HOLD, imem_req=0. On stall release: id_inst=0xDEADBEEF, id_pc=0x20, pc=npc.
REQ-025 Redirect=1 with npc=0x101 while in HOLD -> skid buffer dropped, pc=0x100, id_valid=0, id_inst=0x00000013, fetch_cnt unchanged.
REQ-026 Redirect=1 and stall=1 with ack=1 in the same cycle -> redirect wins: pc=npc, bubble into ID, no HOLD entry.
REQ-027 rst asserted while in HOLD -> next cycle all REQ-019 values. Preload fetch_cnt near 32'hFFFF_FFFF via deliveries -> wraps to 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: drives the PC and instruction memory, and fills the IF/ID register.
// A one-entry skid buffer holds an acked word while the hazard unit stalls decode.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        redirect,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {StFetch, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_d, id_pc_d, id_inst_d, cnt_d;
  logic        id_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d, skid_inst_q, skid_inst_d;
  logic [31:0] npc_aligned;
  logic        unused_npc_low;

  assign npc_aligned    = {npc[31:2], 2'b00};
  assign unused_npc_low = ^npc[1:0];

  assign imem_req  = (state_q == StFetch);
  assign imem_addr = pc;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc;
    id_valid_d  = id_valid;
    id_pc_d     = id_pc;
    id_inst_d   = id_inst;
    cnt_d       = fetch_cnt;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    case (state_q)
      StFetch: begin
        if (redirect) begin
          // Any word acked this cycle belongs to the squashed path.
          pc_d       = npc_aligned;
          id_valid_d = 1'b0;
          id_inst_d  = NOP_INST;
        end else if (imem_ack) begin
          if (stall) begin
            skid_pc_d   = pc;
            skid_inst_d = imem_rdata;
            state_d     = StHold;
          end else begin
            id_pc_d    = pc;
            id_inst_d  = imem_rdata;
            id_valid_d = 1'b1;
            pc_d       = npc_aligned;
            cnt_d      = fetch_cnt + 32'd1;
          end
        end else if (!stall) begin
          id_valid_d = 1'b0;
          id_inst_d  = NOP_INST;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d       = npc_aligned;
          id_valid_d = 1'b0;
          id_inst_d  = NOP_INST;
          state_d    = StFetch;
        end else if (!stall) begin
          id_pc_d    = skid_pc_q;
          id_inst_d  = skid_inst_q;
          id_valid_d = 1'b1;
          pc_d       = npc_aligned;
          cnt_d      = fetch_cnt + 32'd1;
          state_d    = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_pc       <= 32'd0;
      id_inst     <= NOP_INST;
      fetch_cnt   <= 32'd0;
      skid_pc_q   <= 32'd0;
      skid_inst_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      id_valid    <= id_valid_d;
      id_pc       <= id_pc_d;
      id_inst     <= id_inst_d;
      fetch_cnt   <= cnt_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

endmodule
